// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding request, fixed LATENCY, byte-enabled writes.
// Define DM_WRITE_LOG_EN to print one line per committed non-error write.
module dm_responder #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_pc;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [WORDS];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_err;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_wr_word;

    assign w_accept = (r_state == StIdle) && req_valid;
    // Every request passes through WAIT so the commit edge sees latched fields;
    // LATENCY==1 simply starts WAIT with the counter already at 0.
    assign w_commit = (r_state == StWait) && (r_cnt == 4'd0);
    assign w_err    = (r_addr[1:0] != 2'b00) || ((r_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign w_idx    = r_addr[DEPTH_LOG2+1:2];

    always_comb begin
        w_wr_word = r_mem[w_idx];
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
                w_wr_word[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (req_valid) w_state_next = StWait;
            StWait:  if (r_cnt == 4'd0) w_state_next = StResp;
            StResp:  if (rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_pc    <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_we    <= req_we;
                r_be    <= req_be;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_pc    <= req_pc;
            end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_we) ? 32'd0 : r_mem[w_idx];
            end else if ((r_state == StResp) && rsp_ready) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_commit && r_we && !w_err) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && w_commit && r_we && !w_err) begin
            $display("@%08h: *%08h <= %08h", r_pc, {r_addr[31:2], 2'b00}, w_wr_word);
        end
    end
`else
    // The PC only feeds the write log.
    logic w_unused_pc;
    assign w_unused_pc = ^r_pc;
`endif

    assign req_ready = (r_state == StIdle);
    assign rsp_valid = (r_state == StResp);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: instance 0 runs LATENCY=2, instance 1 runs LATENCY=1.
// A transaction-level model is compared against both instances every cycle.
module tb_dm_responder;

    localparam int NWORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [3:0]  req_be    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] req_pc    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_pass  = 0;
    int n_total = 0;
    int lat_p [2] = '{2, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dm_responder #(
            .LATENCY   (g == 0 ? 2 : 1),
            .DEPTH_LOG2(10)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_be   (req_be[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_pc   (req_pc[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Transaction model: one outstanding request, response visible LATENCY edges after accept.
    logic        m_on = 1'b0;
    logic        m_busy  [2];
    int          m_left  [2];
    logic        m_we    [2];
    logic [3:0]  m_be    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    logic        m_err   [2];
    logic [31:0] m_mem   [2][NWORDS];

    task automatic resolve(input int k);
        int unsigned a;
        a        = m_addr[k];
        m_err[k] = (a % 4 != 0) || (a >= 4 * NWORDS);
        m_rdata[k] = 32'd0;
        if (!m_err[k]) begin
            if (m_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[k][b]) m_mem[k][a / 4][8*b +: 8] = m_wdata[k][8*b +: 8];
            end else begin
                m_rdata[k] = m_mem[k][a / 4];
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            for (int k = 0; k < 2; k++) begin
                logic ev;
                ev = m_busy[k] && (m_left[k] == 0);
                chk($sformatf("k%0d req_ready", k), 32'(req_ready[k]), 32'(!m_busy[k]));
                chk($sformatf("k%0d rsp_valid", k), 32'(rsp_valid[k]), 32'(ev));
                chk($sformatf("k%0d rsp_rdata", k), rsp_rdata[k], ev ? m_rdata[k] : 32'd0);
                chk($sformatf("k%0d rsp_err", k), 32'(rsp_err[k]), ev ? 32'(m_err[k]) : 32'd0);
            end
        end
        // Inputs seen now are what the next rising edge samples.
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 1'b0;
                m_left[k] = 0;
                for (int w = 0; w < NWORDS; w++) m_mem[k][w] = 32'd0;
            end else if (!m_busy[k]) begin
                if (req_valid[k]) begin
                    m_busy[k]  = 1'b1;
                    m_left[k]  = lat_p[k];
                    m_we[k]    = req_we[k];
                    m_be[k]    = req_be[k];
                    m_addr[k]  = req_addr[k];
                    m_wdata[k] = req_wdata[k];
                end
            end else if (m_left[k] == 0) begin
                if (rsp_ready[k]) m_busy[k] = 1'b0;
            end else begin
                m_left[k]--;
                if (m_left[k] == 0) resolve(k);
            end
        end
        if (reset) m_on = 1'b1;
    end

    // Called #1 after a rising edge; returns #1 after the handshake edge.
    task automatic txn(input int k, input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input logic [31:0] exp_rdata,
                       input logic exp_err, input string nm);
        int n;
        int lat;
        logic [31:0] held;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_be[k]    = be;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_pc[k]    = $urandom;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk({nm, " accept timeout"}, 32'(n), 32'd0);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 0;
        while (!rsp_valid[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(lat_p[k]));
        chk({nm, " rdata"}, rsp_rdata[k], exp_rdata);
        chk({nm, " err"}, 32'(rsp_err[k]), 32'(exp_err));
        held = rsp_rdata[k];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, " hold valid"}, 32'(rsp_valid[k]), 32'd1);
            chk({nm, " hold ready"}, 32'(req_ready[k]), 32'd0);
            chk({nm, " hold rdata"}, rsp_rdata[k], held);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        chk({nm, " idle after hs"}, 32'(req_ready[k]), 32'd1);
        chk({nm, " valid after hs"}, 32'(rsp_valid[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rdy_at[$];
        int val_at[$];
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_be[k]    = 4'd0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
            req_pc[k]    = 32'd0;
            rsp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset req_ready", 32'(req_ready[0]), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset rsp_rdata", rsp_rdata[0], 32'd0);
        chk("reset rsp_err", 32'(rsp_err[0]), 32'd0);
        @(posedge clk); #1;

        txn(0, 1'b1, 4'hF, 32'h10, 32'h12345678, 0, 32'd0, 1'b0, "wr10");
        txn(0, 1'b0, 4'h0, 32'h10, 32'd0, 0, 32'h12345678, 1'b0, "rd10");
        txn(0, 1'b1, 4'b0010, 32'h10, 32'h0000AB00, 0, 32'd0, 1'b0, "wr10 be2");
        txn(0, 1'b0, 4'h0, 32'h10, 32'd0, 0, 32'h1234AB78, 1'b0, "rd10 merged");
        txn(0, 1'b0, 4'h0, 32'h13, 32'd0, 0, 32'd0, 1'b1, "rd13 misaligned");
        txn(0, 1'b0, 4'h0, 32'h1000, 32'd0, 0, 32'd0, 1'b1, "rd1000 range");
        txn(0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 0, 32'd0, 1'b0, "wr10 be0");
        txn(0, 1'b0, 4'h0, 32'h10, 32'd0, 0, 32'h1234AB78, 1'b0, "rd10 unchanged");
        txn(0, 1'b1, 4'hF, 32'hFFC, 32'hA5A55A5A, 0, 32'd0, 1'b0, "wrFFC");
        txn(0, 1'b0, 4'h0, 32'hFFC, 32'd0, 5, 32'hA5A55A5A, 1'b0, "rdFFC stall");
        txn(0, 1'b1, 4'b1001, 32'hFFC, 32'h11223344, 0, 32'd0, 1'b0, "wrFFC be9");
        txn(0, 1'b0, 4'h0, 32'hFFC, 32'd0, 0, 32'h11A55A44, 1'b0, "rdFFC merged");
        txn(0, 1'b1, 4'hF, 32'h1000, 32'hDEADBEEF, 0, 32'd0, 1'b1, "wr1000 range");
        txn(0, 1'b0, 4'h0, 32'h0, 32'd0, 0, 32'd0, 1'b0, "rd0 no alias");

        // Reset while a write sits in WAIT.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_be[0]    = 4'hF;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset        = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("wait-reset req_ready", 32'(req_ready[0]), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("wait-reset no rsp", 32'(rsp_valid[0]), 32'd0);
        end
        txn(0, 1'b0, 4'h0, 32'h20, 32'd0, 0, 32'd0, 1'b0, "rd20 after reset");

        // LATENCY=1 with a request held continuously and the response always taken.
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 32'h0;
        rsp_ready[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready[1]) rdy_at.push_back(c);
            if (rsp_valid[1]) val_at.push_back(c);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;
        chk("lat1 accept count", 32'(rdy_at.size()), 32'd4);
        chk("lat1 rsp count", 32'(val_at.size()), 32'd4);
        if (rdy_at.size() == 4 && val_at.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                if (i < 3) chk("lat1 accept spacing", 32'(rdy_at[i+1] - rdy_at[i]), 32'd3);
                chk("lat1 rsp offset", 32'(val_at[i] - rdy_at[i]), 32'd2);
            end
        end
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
